// File: rtl/vrf_pkg.sv
// Shared VRF read-path types: sequencer states and the operand word carried through the FIFO.
package vrf_pkg;
  localparam int VRF_READ_LAT  = 2;
  localparam int VRF_MEM_WIDTH = 32;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ISSUE, SEQ_DRAIN} vrf_seq_state_t;

  typedef struct packed {
    logic [VRF_MEM_WIDTH-1:0] data;
    logic                     last;
  } vrf_op_t;
endpackage

// File: rtl/vrf_read_sequencer_if.sv
// Request, VRF read-port and operand handshake bundle for one sequencer.
interface vrf_read_sequencer_if #(
  parameter int AW        = 10,
  parameter int MEM_WIDTH = 32,
  parameter int LEN_WIDTH = 11
);
  logic                 flush_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AW-1:0]        req_base_addr_i;
  logic [LEN_WIDTH-1:0] req_len_i;
  logic [AW-1:0]        vrf_raddr_o;
  logic                 vrf_ren_o;
  logic                 vrf_oreg_ren_o;
  logic [MEM_WIDTH-1:0] vrf_data_i;
  logic                 op_valid_o;
  logic                 op_ready_i;
  logic [MEM_WIDTH-1:0] op_data_o;
  logic                 op_last_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  flush_i, req_valid_i, req_base_addr_i, req_len_i, vrf_data_i, op_ready_i,
    output req_ready_o, vrf_raddr_o, vrf_ren_o, vrf_oreg_ren_o,
           op_valid_o, op_data_o, op_last_o, busy_o, done_o
  );

  modport master (
    output flush_i, req_valid_i, req_base_addr_i, req_len_i, vrf_data_i, op_ready_i,
    input  req_ready_o, vrf_raddr_o, vrf_ren_o, vrf_oreg_ren_o,
           op_valid_o, op_data_o, op_last_o, busy_o, done_o
  );
endinterface

// File: rtl/vrf_op_fifo.sv
// Operand FIFO between the VRF return path and the ALU; push is never issued when full.
module vrf_op_fifo
  import vrf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  vrf_op_t       din,
  input  logic          pop,
  output vrf_op_t       dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  vrf_op_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/vrf_read_sequencer.sv
// Per-port VRF operand sequencer: issues row reads, tracks the fixed read latency,
// and streams returned words to the ALU through a small FIFO.
module vrf_read_sequencer
  import vrf_pkg::*;
#(
  parameter  int MEM_DEPTH  = 1024,
  parameter  int MEM_WIDTH  = VRF_MEM_WIDTH,
  parameter  int FIFO_DEPTH = 4,
  parameter  int LEN_WIDTH  = 11,
  localparam int AW         = $clog2(MEM_DEPTH),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst,
  vrf_read_sequencer_if.slave bus
);
  vrf_seq_state_t          state;
  logic [AW-1:0]           cur_addr;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [VRF_READ_LAT:1]   vld_pipe, last_pipe;
  logic                    oreg_ren, done;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [CW:0]             committed;
  logic                    ren, issue_last, pop;
  vrf_op_t                 push_op, head;

  // FIFO slots already spoken for: stored words plus reads still in the VRF pipe.
  always_comb begin
    committed = {1'b0, fifo_count};
    for (int i = 1; i <= VRF_READ_LAT; i++) committed = committed + (CW+1)'(vld_pipe[i]);
  end

  assign ren        = (state == SEQ_ISSUE) && !bus.flush_i && (committed < (CW+1)'(FIFO_DEPTH));
  assign issue_last = (remaining == LEN_WIDTH'(1));
  assign pop        = !fifo_empty && bus.op_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (bus.flush_i) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[VRF_READ_LAT-1:1], ren};
      last_pipe <= {last_pipe[VRF_READ_LAT-1:1], ren && issue_last};
    end
  end

  // The output register follows ren regardless of flush; a flushed read just completes unused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oreg_ren <= 1'b0;
    else     oreg_ren <= ren;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.flush_i) begin
        state <= SEQ_IDLE;
      end else begin
        case (state)
          SEQ_IDLE: if (bus.req_valid_i) begin
            cur_addr  <= bus.req_base_addr_i;
            remaining <= bus.req_len_i;
            if (bus.req_len_i == '0) done  <= 1'b1;
            else                     state <= SEQ_ISSUE;
          end
          SEQ_ISSUE: if (ren) begin
            cur_addr  <= (cur_addr == AW'(MEM_DEPTH - 1)) ? '0 : cur_addr + AW'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (issue_last) state <= SEQ_DRAIN;
          end
          SEQ_DRAIN: if (pop && head.last) begin
            state <= SEQ_IDLE;
            done  <= 1'b1;
          end
          default: state <= SEQ_IDLE;
        endcase
      end
    end
  end

  assign push_op.data = VRF_MEM_WIDTH'(bus.vrf_data_i);
  assign push_op.last = last_pipe[VRF_READ_LAT];

  vrf_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush_i),
    .push  (vld_pipe[VRF_READ_LAT]),
    .din   (push_op),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.req_ready_o    = (state == SEQ_IDLE);
  assign bus.busy_o         = (state != SEQ_IDLE);
  assign bus.done_o         = done;
  assign bus.vrf_raddr_o    = cur_addr;
  assign bus.vrf_ren_o      = ren;
  assign bus.vrf_oreg_ren_o = oreg_ren;
  assign bus.op_valid_o     = !fifo_empty;
  assign bus.op_data_o      = fifo_empty ? '0 : MEM_WIDTH'(head.data);
  assign bus.op_last_o      = !fifo_empty && head.last;
endmodule

// File: tb/tb_vrf_read_sequencer.sv
// Directed bench for vrf_read_sequencer: stimulus queues expected reads/operands, a monitor checks them.
module tb_vrf_read_sequencer;
  localparam int AW = 10;
  localparam int MW = 32;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vrf_read_sequencer_if #(.AW(AW), .MEM_WIDTH(MW), .LEN_WIDTH(LW)) bus ();

  vrf_read_sequencer #(.MEM_DEPTH(1024), .MEM_WIDTH(MW), .FIFO_DEPTH(4), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // VRF model: row r reads back as C0DE_0000 | r, two cycles after ren.
  logic [AW-1:0] rd_addr;
  always @(posedge clk) begin
    if (bus.vrf_ren_o)      rd_addr        <= bus.vrf_raddr_o;
    if (bus.vrf_oreg_ren_o) bus.vrf_data_i <= 32'hC0DE_0000 | 32'(rd_addr);
  end

  int errors = 0, checks = 0;
  int ren_cnt = 0, pop_cnt = 0, done_cnt = 0, done_due = -1;
  logic [MW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_row(input logic [AW-1:0] a, input bit last);
    addr_q.push_back(a);
    exp_q.push_back({last, 32'hC0DE_0000 | 32'(a)});
  endtask

  task automatic monitor();
    logic [MW:0]   e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.done_o) begin
          check(cyc == done_due, "done_timing", 64'(cyc), 64'(done_due));
          done_cnt++;
        end
        if (bus.vrf_ren_o) begin
          ren_cnt++;
          if (addr_q.size() == 0) check(1'b0, "unexpected_ren", 64'(bus.vrf_raddr_o), 64'(0));
          else begin
            a = addr_q.pop_front();
            check(bus.vrf_raddr_o == a, "raddr", 64'(bus.vrf_raddr_o), 64'(a));
          end
        end
        if (bus.op_valid_o && bus.op_ready_i) begin
          pop_cnt++;
          if (exp_q.size() == 0) check(1'b0, "unexpected_op", 64'({bus.op_last_o, bus.op_data_o}), 64'(0));
          else begin
            e = exp_q.pop_front();
            check({bus.op_last_o, bus.op_data_o} == e, "op_last_data",
                  64'({bus.op_last_o, bus.op_data_o}), 64'(e));
            if (e[MW]) done_due = cyc + 1;
          end
        end
      end
    end
  endtask

  task automatic req(input logic [AW-1:0] base, input logic [LW-1:0] len);
    int n = 0;
    while (!bus.req_ready_o && n < 50) begin step(); n++; end
    check(bus.req_ready_o == 1'b1, "req_ready_wait", 64'(bus.req_ready_o), 64'(1));
    bus.req_valid_i     = 1'b1;
    bus.req_base_addr_i = base;
    bus.req_len_i       = len;
    if (len == '0) done_due = cyc + 1;
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt <= d0 && n < 200) begin step(); n++; end
    check(done_cnt > d0, "done_seen", 64'(done_cnt), 64'(d0 + 1));
    check(exp_q.size() == 0, "ops_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int d0, r0, p0, n;
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b0; bus.req_base_addr_i = '0;
    bus.req_len_i = '0; bus.op_ready_i = 1'b0;
    fork monitor(); join_none

    // Reset values
    repeat (3) step();
    check(bus.req_ready_o == 1'b1, "rst_req_ready", 64'(bus.req_ready_o), 64'(1));
    check(bus.op_valid_o == 1'b0, "rst_op_valid", 64'(bus.op_valid_o), 64'(0));
    check(bus.busy_o == 1'b0, "rst_busy", 64'(bus.busy_o), 64'(0));
    check(bus.vrf_ren_o == 1'b0, "rst_ren", 64'(bus.vrf_ren_o), 64'(0));
    check(bus.done_o == 1'b0, "rst_done", 64'(bus.done_o), 64'(0));
    rst = 1'b0;
    step();

    // 1: base 5, len 4, ALU always ready
    bus.op_ready_i = 1'b1;
    expect_row(10'd5, 0); expect_row(10'd6, 0); expect_row(10'd7, 0); expect_row(10'd8, 1);
    d0 = done_cnt;
    req(10'd5, 11'd4);
    check(bus.busy_o == 1'b1, "t1_busy", 64'(bus.busy_o), 64'(1));
    check(bus.vrf_ren_o == 1'b1, "t1_first_ren", 64'(bus.vrf_ren_o), 64'(1));
    step(); step();
    check(bus.op_valid_o == 1'b0, "t1_valid_early", 64'(bus.op_valid_o), 64'(0));
    step();
    check(bus.op_valid_o == 1'b1, "t1_valid_latency", 64'(bus.op_valid_o), 64'(1));
    wait_done(d0);

    // 2: wrap-around past the top row
    expect_row(10'd1022, 0); expect_row(10'd1023, 0); expect_row(10'd0, 0); expect_row(10'd1, 1);
    d0 = done_cnt;
    req(10'd1022, 11'd4);
    wait_done(d0);

    // 3: ALU stalled, len 8: only FIFO_DEPTH reads may be issued
    bus.op_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) expect_row(10'(40 + i), i == 7);
    d0 = done_cnt; r0 = ren_cnt;
    req(10'd40, 11'd8);
    repeat (20) step();
    check(ren_cnt - r0 == 4, "t3_ren_stall", 64'(ren_cnt - r0), 64'(4));
    check(bus.op_valid_o == 1'b1, "t3_valid_held", 64'(bus.op_valid_o), 64'(1));
    check(bus.op_data_o == 32'hC0DE_0028, "t3_head", 64'(bus.op_data_o), 64'h0C0DE_0028);
    bus.op_ready_i = 1'b1;
    wait_done(d0);
    check(ren_cnt - r0 == 8, "t3_ren_total", 64'(ren_cnt - r0), 64'(8));

    // 4: zero-length request
    d0 = done_cnt;
    req(10'd0, 11'd0);
    check(bus.done_o == 1'b1, "t4_done", 64'(bus.done_o), 64'(1));
    check(bus.req_ready_o == 1'b1, "t4_req_ready", 64'(bus.req_ready_o), 64'(1));
    check(bus.vrf_ren_o == 1'b0, "t4_no_ren", 64'(bus.vrf_ren_o), 64'(0));
    step();
    check(done_cnt == d0 + 1, "t4_done_count", 64'(done_cnt), 64'(d0 + 1));

    // 5: flush mid-ISSUE after 3 pops, then a clean follow-up request
    for (int i = 0; i < 16; i++) expect_row(10'(200 + i), i == 15);
    d0 = done_cnt; p0 = pop_cnt; n = 0;
    req(10'd200, 11'd16);
    while (pop_cnt < p0 + 3 && n < 100) begin step(); n++; end
    check(pop_cnt >= p0 + 3, "t5_pops_before_flush", 64'(pop_cnt - p0), 64'(3));
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    exp_q.delete(); addr_q.delete(); done_due = -1;
    check(bus.op_valid_o == 1'b0, "t5_flush_valid", 64'(bus.op_valid_o), 64'(0));
    check(bus.busy_o == 1'b0, "t5_flush_idle", 64'(bus.busy_o), 64'(0));
    repeat (5) step();
    check(bus.op_valid_o == 1'b0, "t5_no_stale", 64'(bus.op_valid_o), 64'(0));
    check(done_cnt == d0, "t5_no_done", 64'(done_cnt), 64'(d0));
    expect_row(10'd0, 0); expect_row(10'd1, 1);
    req(10'd0, 11'd2);
    wait_done(d0);

    // 6: asynchronous reset while draining
    bus.op_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) expect_row(10'(100 + i), i == 3);
    req(10'd100, 11'd4);
    repeat (8) step();
    check(bus.busy_o == 1'b1, "t6_busy_pre", 64'(bus.busy_o), 64'(1));
    check(ren_cnt > 0 && addr_q.size() == 0, "t6_all_issued", 64'(addr_q.size()), 64'(0));
    #3 rst = 1'b1;
    #1;
    check(bus.op_valid_o == 1'b0, "t6_rst_valid", 64'(bus.op_valid_o), 64'(0));
    check(bus.busy_o == 1'b0, "t6_rst_busy", 64'(bus.busy_o), 64'(0));
    check(bus.req_ready_o == 1'b1, "t6_rst_ready", 64'(bus.req_ready_o), 64'(1));
    check(bus.vrf_raddr_o == '0, "t6_rst_raddr", 64'(bus.vrf_raddr_o), 64'(0));
    check(bus.op_last_o == 1'b0, "t6_rst_last", 64'(bus.op_last_o), 64'(0));
    exp_q.delete(); addr_q.delete(); done_due = -1;
    step(); step();
    rst = 1'b0;
    step();
    check(bus.op_valid_o == 1'b0, "t6_fifo_empty", 64'(bus.op_valid_o), 64'(0));
    check(bus.done_o == 1'b0, "t6_no_done", 64'(bus.done_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
